// File: rtl/lisnoc_router_output_link.sv
// LISNoC router output port: per-VC packet-locked round-robin arbitration of
// switch inputs into per-VC FIFOs, then round-robin multiplexing of the VCs
// onto one shared valid/ready link towards the neighbouring router.
module lisnoc_router_output_link #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int vchannels       = 1,
  parameter int ports           = 5,
  parameter int fifo_length     = 4
) (
  input  logic                                                       clk,
  input  logic                                                       rst,
  input  logic [vchannels*ports-1:0]                                 switch_request,
  input  logic [vchannels*ports*(flit_data_width+flit_type_width)-1:0] switch_flit,
  output logic [vchannels*ports-1:0]                                 switch_read,
  output logic [flit_data_width+flit_type_width-1:0]                 link_flit,
  output logic [vchannels-1:0]                                       link_valid,
  input  logic [vchannels-1:0]                                       link_ready
);

  localparam int flit_width = flit_data_width + flit_type_width;
  localparam int pw = (ports > 1) ? $clog2(ports) : 1;
  localparam int vw = (vchannels > 1) ? $clog2(vchannels) : 1;
  localparam int aw = (fifo_length > 1) ? $clog2(fifo_length) : 1;
  localparam int cw = $clog2(fifo_length + 1);

  localparam logic [flit_type_width-1:0] type_header = flit_type_width'(2'b01);
  localparam logic [flit_type_width-1:0] type_last   = flit_type_width'(2'b10);

  typedef enum logic {IDLE, LOCKED} state_t;

  logic [vchannels-1:0]  nonempty;
  logic [flit_width-1:0] head [vchannels];
  logic [vw-1:0]         vrr;
  logic [vw-1:0]         vrr_next;

  for (genvar v = 0; v < vchannels; v++) begin : g_vc
    state_t                state;
    state_t                state_next;
    logic [ports-1:0]      owner;
    logic [ports-1:0]      owner_next;
    logic [pw-1:0]         rr;
    logic [pw-1:0]         rr_next;
    logic [ports-1:0]      req;
    logic [ports-1:0]      grant;
    logic [flit_width-1:0] wr_flit;
    logic                  wr_en;
    logic                  rd_en;
    logic                  full;
    logic [flit_width-1:0] mem [fifo_length];
    logic [aw-1:0]         wr_ptr;
    logic [aw-1:0]         rd_ptr;
    logic [cw-1:0]         count;

    assign req         = switch_request[v*ports +: ports];
    assign full        = (count == cw'(fifo_length));
    assign nonempty[v] = (count != '0);
    assign head[v]     = mem[rd_ptr];
    assign wr_en       = |grant;
    assign rd_en       = link_valid[v] & link_ready[v];
    assign switch_read[v*ports +: ports] = grant;

    // Arbiter: round-robin grant when idle, serve only the lock owner mid-packet
    always_comb begin : arb
      logic found;
      int   idx;
      state_next = state;
      owner_next = owner;
      rr_next    = rr;
      grant      = '0;
      wr_flit    = '0;
      found      = 1'b0;
      idx        = 0;
      if (!rst && !full) begin
        if (state == IDLE) begin
          for (int i = 0; i < ports; i++) begin
            if (!found && req[(int'(rr) + i) % ports]) begin
              found = 1'b1;
              idx   = (int'(rr) + i) % ports;
            end
          end
          if (found) begin
            grant[idx] = 1'b1;
            wr_flit    = switch_flit[(v*ports + idx)*flit_width +: flit_width];
            rr_next    = (idx == ports - 1) ? '0 : pw'(idx + 1);
            if (wr_flit[flit_width-1 -: flit_type_width] == type_header) begin
              owner_next = grant;
              state_next = LOCKED;
            end
          end
        end else begin
          for (int p = 0; p < ports; p++) begin
            if (owner[p] && req[p]) begin
              grant[p] = 1'b1;
              wr_flit  = switch_flit[(v*ports + p)*flit_width +: flit_width];
            end
          end
          if (wr_en && (wr_flit[flit_width-1 -: flit_type_width] == type_last)) begin
            state_next = IDLE;
            owner_next = '0;
          end
        end
      end
    end

    // Arbiter state, lock owner and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= IDLE;
        owner <= '0;
        rr    <= '0;
      end else begin
        state <= state_next;
        owner <= owner_next;
        rr    <= rr_next;
      end
    end

    // FIFO pointers and occupancy; a full FIFO never accepts, even while draining
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en) begin
          wr_ptr <= (wr_ptr == aw'(fifo_length - 1)) ? '0 : wr_ptr + 1'b1;
        end
        if (rd_en) begin
          rd_ptr <= (rd_ptr == aw'(fifo_length - 1)) ? '0 : rd_ptr + 1'b1;
        end
        if (wr_en && !rd_en) begin
          count <= count + 1'b1;
        end else if (!wr_en && rd_en) begin
          count <= count - 1'b1;
        end
      end
    end

    // FIFO storage, no reset needed since occupancy guards every read
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_flit;
      end
    end
  end

  // Link mux: prefer VCs that can transfer now, else present a stalled one
  always_comb begin : link_sel
    logic [vchannels-1:0] mask;
    logic                 found;
    int                   sel;
    mask       = (|(nonempty & link_ready)) ? (nonempty & link_ready) : nonempty;
    found      = 1'b0;
    sel        = 0;
    link_valid = '0;
    link_flit  = '0;
    vrr_next   = vrr;
    for (int i = 0; i < vchannels; i++) begin
      if (!found && mask[(int'(vrr) + i) % vchannels]) begin
        found = 1'b1;
        sel   = (int'(vrr) + i) % vchannels;
      end
    end
    if (found) begin
      link_valid[sel] = 1'b1;
      link_flit       = head[sel];
      if (link_ready[sel]) begin
        vrr_next = (sel == vchannels - 1) ? '0 : vw'(sel + 1);
      end
    end
  end

  // VC round-robin pointer advances only on an actual link transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vrr <= '0;
    end else begin
      vrr <= vrr_next;
    end
  end

endmodule

// File: tb/tb_lisnoc_router_output_link.sv
// Directed bench for lisnoc_router_output_link with two VCs and five inputs.
module tb_lisnoc_router_output_link;

  localparam int FW = 34;

  logic          clk;
  logic          rst;
  logic [9:0]    switch_request;
  logic [339:0]  switch_flit;
  logic [9:0]    switch_read;
  logic [FW-1:0] link_flit;
  logic [1:0]    link_valid;
  logic [1:0]    link_ready;

  int compared;
  int mismatched;

  lisnoc_router_output_link #(
    .flit_data_width(32),
    .flit_type_width(2),
    .vchannels(2),
    .ports(5),
    .fifo_length(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .switch_request(switch_request),
    .switch_flit(switch_flit),
    .switch_read(switch_read),
    .link_flit(link_flit),
    .link_valid(link_valid),
    .link_ready(link_ready)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] d);
    return {t, d};
  endfunction

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_in();
    switch_request = '0;
    switch_flit    = '0;
  endtask

  task automatic apply_stimulus(input int v, input int p, input logic [FW-1:0] f);
    switch_request[v*5 + p]      = 1'b1;
    switch_flit[(v*5 + p)*FW +: FW] = f;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    clear_in();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed test sequence
  initial begin
    logic [1:0] TH;
    logic [1:0] TP;
    logic [1:0] TL;
    logic [1:0] TS;
    int         order [5];
    TH = 2'b01; TP = 2'b00; TL = 2'b10; TS = 2'b11;
    order = '{0, 1, 2, 3, 0};
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    link_ready = 2'b00;
    clear_in();

    // reset state
    #2;
    check_output("rst_valid", 64'(link_valid), 64'h0);
    check_output("rst_flit", 64'(link_flit), 64'h0);
    check_output("rst_read", 64'(switch_read), 64'h0);
    apply_stimulus(0, 0, mk(TS, 32'h1));
    #1;
    check_output("rst_read_forced", 64'(switch_read), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    clear_in();
    link_ready = 2'b11;

    // single flit latency
    @(negedge clk); clear_in(); apply_stimulus(0, 2, mk(TS, 32'hC0000001)); #1;
    check_output("t1_read", 64'(switch_read), 64'h004);
    check_output("t1_valid0", 64'(link_valid), 64'h0);
    @(negedge clk); clear_in(); #1;
    check_output("t1_valid1", 64'(link_valid), 64'h1);
    check_output("t1_flit1", 64'(link_flit), 64'(mk(TS, 32'hC0000001)));
    @(negedge clk); #1;
    check_output("t1_valid2", 64'(link_valid), 64'h0);
    check_output("t1_flit2", 64'(link_flit), 64'h0);

    // packet locking between inputs 0 and 3
    reset_pulse();
    @(negedge clk); clear_in(); apply_stimulus(0, 0, mk(TH, 32'h00)); apply_stimulus(0, 3, mk(TH, 32'h30)); #1;
    check_output("t2_a_read", 64'(switch_read), 64'h001);
    @(negedge clk); clear_in(); apply_stimulus(0, 0, mk(TP, 32'h01)); apply_stimulus(0, 3, mk(TH, 32'h30)); #1;
    check_output("t2_b_read", 64'(switch_read), 64'h001);
    check_output("t2_b_flit", 64'(link_flit), 64'(mk(TH, 32'h00)));
    @(negedge clk); clear_in(); apply_stimulus(0, 0, mk(TL, 32'h02)); apply_stimulus(0, 3, mk(TH, 32'h30)); #1;
    check_output("t2_c_read", 64'(switch_read), 64'h001);
    check_output("t2_c_flit", 64'(link_flit), 64'(mk(TP, 32'h01)));
    @(negedge clk); clear_in(); apply_stimulus(0, 3, mk(TH, 32'h30)); #1;
    check_output("t2_d_read", 64'(switch_read), 64'h008);
    check_output("t2_d_flit", 64'(link_flit), 64'(mk(TL, 32'h02)));
    @(negedge clk); clear_in(); apply_stimulus(0, 3, mk(TP, 32'h31)); #1;
    check_output("t2_e_read", 64'(switch_read), 64'h008);
    check_output("t2_e_flit", 64'(link_flit), 64'(mk(TH, 32'h30)));
    @(negedge clk); clear_in(); apply_stimulus(0, 3, mk(TL, 32'h32)); #1;
    check_output("t2_f_flit", 64'(link_flit), 64'(mk(TP, 32'h31)));
    @(negedge clk); clear_in(); #1;
    check_output("t2_g_flit", 64'(link_flit), 64'(mk(TL, 32'h32)));
    @(negedge clk); #1;
    check_output("t2_h_valid", 64'(link_valid), 64'h0);

    // full FIFO backpressure
    reset_pulse();
    link_ready = 2'b00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); clear_in(); apply_stimulus(0, 1, mk(TS, 32'(k + 1))); #1;
      check_output($sformatf("t3_fill_read%0d", k), 64'(switch_read), 64'h002);
    end
    check_output("t3_stall_valid", 64'(link_valid), 64'h1);
    check_output("t3_stall_flit", 64'(link_flit), 64'(mk(TS, 32'h1)));
    @(negedge clk); clear_in(); apply_stimulus(0, 1, mk(TS, 32'h5)); #1;
    check_output("t3_full_read", 64'(switch_read), 64'h0);
    @(negedge clk); link_ready = 2'b11; #1;
    check_output("t3_nobypass_read", 64'(switch_read), 64'h0);
    check_output("t3_drain_flit1", 64'(link_flit), 64'(mk(TS, 32'h1)));
    @(negedge clk); #1;
    check_output("t3_free_read", 64'(switch_read), 64'h002);
    check_output("t3_drain_flit2", 64'(link_flit), 64'(mk(TS, 32'h2)));
    for (int c = 3; c <= 5; c++) begin
      @(negedge clk); clear_in(); #1;
      check_output($sformatf("t3_drain_flit%0d", c), 64'(link_flit), 64'(mk(TS, 32'(c))));
    end
    @(negedge clk); #1;
    check_output("t3_empty_valid", 64'(link_valid), 64'h0);

    // two VCs sharing the link
    reset_pulse();
    link_ready = 2'b00;
    @(negedge clk); clear_in(); apply_stimulus(0, 0, mk(TS, 32'hA0)); apply_stimulus(1, 0, mk(TS, 32'hB0)); #1;
    check_output("t4_a_read", 64'(switch_read), 64'h021);
    @(negedge clk); clear_in(); apply_stimulus(0, 0, mk(TS, 32'hA1)); apply_stimulus(1, 0, mk(TS, 32'hB1)); #1;
    check_output("t4_b_read", 64'(switch_read), 64'h021);
    check_output("t4_b_valid", 64'(link_valid), 64'h1);
    @(negedge clk); clear_in(); link_ready = 2'b11; #1;
    check_output("t4_c_valid", 64'(link_valid), 64'h1);
    check_output("t4_c_flit", 64'(link_flit), 64'(mk(TS, 32'hA0)));
    @(negedge clk); #1;
    check_output("t4_d_valid", 64'(link_valid), 64'h2);
    check_output("t4_d_flit", 64'(link_flit), 64'(mk(TS, 32'hB0)));
    @(negedge clk); #1;
    check_output("t4_e_valid", 64'(link_valid), 64'h1);
    check_output("t4_e_flit", 64'(link_flit), 64'(mk(TS, 32'hA1)));
    @(negedge clk); #1;
    check_output("t4_f_valid", 64'(link_valid), 64'h2);
    check_output("t4_f_flit", 64'(link_flit), 64'(mk(TS, 32'hB1)));
    @(negedge clk); #1;
    check_output("t4_g_valid", 64'(link_valid), 64'h0);
    @(negedge clk); link_ready = 2'b01; clear_in(); apply_stimulus(0, 2, mk(TS, 32'hA2)); apply_stimulus(1, 2, mk(TS, 32'hB2)); #1;
    check_output("t4_h_read", 64'(switch_read), 64'h084);
    @(negedge clk); clear_in(); apply_stimulus(1, 3, mk(TS, 32'hB3)); #1;
    check_output("t4_i_read", 64'(switch_read), 64'h100);
    check_output("t4_i_valid", 64'(link_valid), 64'h1);
    check_output("t4_i_flit", 64'(link_flit), 64'(mk(TS, 32'hA2)));
    @(negedge clk); clear_in(); #1;
    check_output("t4_j_valid", 64'(link_valid), 64'h2);
    check_output("t4_j_flit", 64'(link_flit), 64'(mk(TS, 32'hB2)));
    @(negedge clk); #1;
    check_output("t4_k_flit", 64'(link_flit), 64'(mk(TS, 32'hB2)));
    @(negedge clk); link_ready = 2'b11; #1;
    check_output("t4_l_flit", 64'(link_flit), 64'(mk(TS, 32'hB2)));
    @(negedge clk); #1;
    check_output("t4_m_flit", 64'(link_flit), 64'(mk(TS, 32'hB3)));
    @(negedge clk); #1;
    check_output("t4_n_valid", 64'(link_valid), 64'h0);

    // reset in the middle of a packet
    reset_pulse();
    link_ready = 2'b00;
    @(negedge clk); clear_in(); apply_stimulus(0, 1, mk(TH, 32'h51)); #1;
    check_output("t5_hdr_read", 64'(switch_read), 64'h002);
    @(negedge clk); clear_in(); #1;
    check_output("t5_held_valid", 64'(link_valid), 64'h1);
    rst = 1'b1; #1;
    check_output("t5_rst_valid", 64'(link_valid), 64'h0);
    check_output("t5_rst_flit", 64'(link_flit), 64'h0);
    apply_stimulus(0, 4, mk(TH, 32'h54)); #1;
    check_output("t5_rst_read", 64'(switch_read), 64'h0);
    @(negedge clk); rst = 1'b0; link_ready = 2'b11; #1;
    check_output("t5_new_read", 64'(switch_read), 64'h010);
    @(negedge clk); clear_in(); #1;
    check_output("t5_new_valid", 64'(link_valid), 64'h1);
    check_output("t5_new_flit", 64'(link_flit), 64'(mk(TH, 32'h54)));

    // round-robin fairness among four inputs
    reset_pulse();
    link_ready = 2'b11;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); clear_in();
      for (int p = 0; p < 4; p++) apply_stimulus(0, p, mk(TS, 32'(32'h100 + p)));
      #1;
      check_output($sformatf("t6_grant%0d", c), 64'(switch_read), 64'(10'd1 << order[c]));
      if (c > 0) begin
        check_output($sformatf("t6_flit%0d", c), 64'(link_flit), 64'(mk(TS, 32'(32'h100 + order[c-1]))));
      end
    end
    @(negedge clk); clear_in(); #1;
    check_output("t6_last_flit", 64'(link_flit), 64'(mk(TS, 32'h100)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
